// File: rtl/mux4_scan_serializer_pkg.sv
// Shared types and select-index helpers for the 4-channel scan serializer.
package mux4_scan_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic [1:0] SEL_IDX_LO = 2'd0;
  localparam logic [1:0] SEL_IDX_HI = 2'd3;

  function automatic logic [1:0] sel_start(input bit msb_first);
    return msb_first ? SEL_IDX_HI : SEL_IDX_LO;
  endfunction

  function automatic logic [1:0] sel_end(input bit msb_first);
    return msb_first ? SEL_IDX_LO : SEL_IDX_HI;
  endfunction

  // Two-bit arithmetic wraps naturally, but the FSM never steps past the last bit.
  function automatic logic [1:0] sel_step(input logic [1:0] sel, input bit msb_first);
    return msb_first ? (sel - 2'd1) : (sel + 2'd1);
  endfunction

endpackage

// File: rtl/mux4_scan_serializer_if.sv
// Word-in / serial-out bundle between the upstream producer and the scan serializer.
interface mux4_scan_serializer_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [1:0] sel;
  logic       ser_out;
  logic       ser_valid;
  logic       bit_strobe;
  logic       ser_last;
  logic       busy;

  modport slave (
    input  in_valid, in_data,
    output in_ready, sel, ser_out, ser_valid, bit_strobe, ser_last, busy
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, sel, ser_out, ser_valid, bit_strobe, ser_last, busy
  );
endinterface

// File: rtl/mux4x1.sv
// Plain 4:1 bit multiplexer: Y = I[Sel].
module mux4x1 (
  input  logic [3:0] I,
  input  logic [1:0] Sel,
  output logic       Y
);
  always_comb begin
    Y = I[Sel];
  end
endmodule

// File: rtl/mux4_scan_serializer.sv
// Accepts a 4-bit word and scans it out one channel at a time through a mux4x1,
// holding each select value for BIT_CYCLES clocks.
module mux4_scan_serializer
  import mux4_scan_serializer_pkg::*;
#(
  parameter int BIT_CYCLES = 1,
  parameter int MSB_FIRST  = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  mux4_scan_serializer_if.slave         bus
);

  localparam int PW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_MAX   = PW'(BIT_CYCLES - 1);
  localparam bit            MSB       = (MSB_FIRST != 0);
  localparam logic [1:0]    SEL_FIRST = sel_start(MSB);

  if (BIT_CYCLES < 1) begin : g_bad_bit_cycles
    $error("mux4_scan_serializer: BIT_CYCLES must be >= 1");
  end

  state_t          state_q, state_d;
  logic [3:0]      hold_q, hold_d;
  logic [1:0]      sel_q, sel_d;
  logic [1:0]      bit_cnt_q, bit_cnt_d;
  logic [PW-1:0]   pre_q, pre_d;

  logic            bit_wrap;
  logic            last_cycle;
  logic            accept_ok;
  logic            ser_out_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      hold_q    <= 4'b0000;
      sel_q     <= 2'd0;
      bit_cnt_q <= 2'd0;
      pre_q     <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      sel_q     <= sel_d;
      bit_cnt_q <= bit_cnt_d;
      pre_q     <= pre_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    sel_d      = sel_q;
    bit_cnt_d  = bit_cnt_q;
    pre_d      = pre_q;
    bit_wrap   = (pre_q == PRE_MAX);
    last_cycle = (state_q == ST_SHIFT) && bit_wrap && (bit_cnt_q == 2'd3);
    accept_ok  = (state_q == ST_IDLE) || last_cycle;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_d   = ST_SHIFT;
          hold_d    = bus.in_data;
          sel_d     = SEL_FIRST;
          bit_cnt_d = 2'd0;
          pre_d     = '0;
        end
      end

      ST_SHIFT: begin
        if (!bit_wrap) begin
          pre_d = pre_q + 1'b1;
        end else if (bit_cnt_q != 2'd3) begin
          pre_d     = '0;
          bit_cnt_d = bit_cnt_q + 2'd1;
          sel_d     = sel_step(sel_q, MSB);
        end else if (bus.in_valid) begin
          // Final cycle with a word waiting: restart with no idle gap.
          hold_d    = bus.in_data;
          sel_d     = SEL_FIRST;
          bit_cnt_d = 2'd0;
          pre_d     = '0;
        end else begin
          // Frame done; sel parks on the last channel scanned.
          state_d   = ST_IDLE;
          sel_d     = sel_end(MSB);
          bit_cnt_d = 2'd0;
          pre_d     = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  mux4x1 u_mux (
    .I   (hold_q),
    .Sel (sel_q),
    .Y   (ser_out_w)
  );

  assign bus.in_ready   = accept_ok & ~rst;
  assign bus.sel        = sel_q;
  assign bus.ser_out    = ser_out_w;
  assign bus.ser_valid  = (state_q == ST_SHIFT);
  assign bus.busy       = (state_q == ST_SHIFT);
  assign bus.bit_strobe = (state_q == ST_SHIFT) && (pre_q == '0);
  assign bus.ser_last   = (state_q == ST_SHIFT) && (bit_cnt_q == 2'd3);

endmodule
